// File: rtl/seq_multiplier_pkg.sv
// Shared types and constants for the shift-add sequential multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_multiplier_pkg;

  // Default operand width in bits.
  localparam int DEFAULT_N = 18;

  // Controller states: wait for start, iterate N times, one-cycle completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/result bundle between a multiply requester and seq_multiplier.
// Latency: n/a (wires only).
// Backpressure: none; start is only accepted while the multiplier is idle.
// Ports (signals):
//   start   - request a multiply (master -> slave)
//   a, b    - unsigned operands, N bits each (master -> slave)
//   busy    - multiplier is iterating (slave -> master)
//   done    - one-cycle completion strobe (slave -> master)
//   product - last completed 2N-bit product (slave -> master)
interface seq_multiplier_if
  import seq_multiplier_pkg::*;
#(
  parameter int N = DEFAULT_N
) ();

  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/seq_multiplier_adderN.sv
// N-bit ripple-carry adder used for the multiplier's add step.
// Latency: purely combinational.
// Backpressure: n/a.
// Ports: a_i, b_i - addends; cin_i - carry in; sum_o - N-bit sum; cout_o - carry out.
module adderN
  import seq_multiplier_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  // Carry is walked bit by bit through a block-local variable so the chain
  // stays a simple ripple without a self-referencing vector net.
  always_comb begin
    logic carry;
    carry = cin_i;
    sum_o = '0;
    for (int i = 0; i < N; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned N x N sequential shift-add multiplier producing a 2N-bit product.
// Latency: N cycles from accepted start to done; N+2 cycles per operation back to back.
// Backpressure: start is sampled only in IDLE; starts during RUN/DONE are dropped, not queued.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   mul   - slave side of seq_multiplier_if (start/a/b in, busy/done/product out)
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_multiplier_if.slave  mul
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state_q;
  logic [2*N-1:0] p_q;        // {partial sum, remaining multiplier bits}
  logic [N-1:0]   m_q;        // latched multiplicand
  logic [CW-1:0]  cnt_q;      // iterations completed in this run
  logic           busy_q;
  logic           done_q;
  logic [2*N-1:0] product_q;

  logic [N-1:0]   sum;
  logic           cout;
  logic [2*N-1:0] p_d;

  adderN #(
    .N (N)
  ) u_adder (
    .a_i    (p_q[2*N-1:N]),
    .b_i    (m_q),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (cout)
  );

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift right with the carry entering
  // at the top so no bit of the exact 2N-bit result is lost.
  always_comb begin
    if (p_q[0]) begin
      p_d = {cout, sum, p_q[N-1:1]};
    end else begin
      p_d = {1'b0, p_q[2*N-1:1]};
    end
  end

  // Controller with registered busy/done so neither has a path from start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      p_q       <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (mul.start) begin
            p_q     <= {{N{1'b0}}, mul.b};
            m_q     <= mul.a;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          p_q   <= p_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            // Final step: publish this step's result directly so product is
            // valid in the same cycle done rises.
            product_q <= p_d;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mul.busy    = busy_q;
  assign mul.done    = done_q;
  assign mul.product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier against a plain a*b reference.
// Latency: checks N-cycle latency, single-cycle done, and N+2 back-to-back spacing.
// Backpressure: checks that starts during RUN/DONE are ignored.
module tb_seq_multiplier;
  import seq_multiplier_pkg::*;

  localparam int N = DEFAULT_N;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seq_multiplier_if #(.N(N)) mif ();

  seq_multiplier #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mul   (mif)
  );

  int checks    = 0;
  int failures  = 0;
  int done_cnt  = 0;

  // Count completion strobes; read only on the falling edge.
  always @(posedge clk) begin
    if (mif.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one multiply from a falling edge in IDLE and check it to completion.
  // With hold set, start stays high (with different operands) through RUN.
  task automatic do_op(input logic [N-1:0] av, input logic [N-1:0] bv, input bit hold);
    logic [63:0] exp;
    logic [63:0] prev;
    int lat;
    int busy_n;
    int d0;
    exp    = 64'(av) * 64'(bv);
    prev   = 64'(mif.product);
    d0     = done_cnt;
    lat    = -1;
    busy_n = 0;
    chk("idle_busy", 64'(mif.busy), 64'd0);
    mif.a     = av;
    mif.b     = bv;
    mif.start = 1'b1;
    @(posedge clk);
    #1;
    if (hold) begin
      mif.a = N'(2);
      mif.b = N'(2);
    end else begin
      mif.start = 1'b0;
      mif.a     = N'($urandom);
      mif.b     = N'($urandom);
    end
    for (int k = 1; k <= N + 4; k++) begin
      @(negedge clk);
      if (mif.done === 1'b1) begin
        lat = k - 1;
        break;
      end
      if (mif.busy === 1'b1) busy_n++;
      chk("product_stable", 64'(mif.product), prev);
    end
    chk("latency", 64'(lat), 64'(N));
    chk("busy_cycles", 64'(busy_n), 64'(N));
    chk("product", 64'(mif.product), exp);
    chk("busy_at_done", 64'(mif.busy), 64'd0);
    if (hold) mif.start = 1'b0;
    @(negedge clk);
    chk("done_width", 64'(mif.done), 64'd0);
    chk("done_count", 64'(done_cnt - d0), 64'd1);
    chk("product_after", 64'(mif.product), exp);
  endtask

  initial begin
    int d0;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic [N-1:0] ones;
    ones      = '1;
    mif.start = 1'b0;
    mif.a     = '0;
    mif.b     = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(mif.busy), 64'd0);
    chk("rst_done", 64'(mif.done), 64'd0);
    chk("rst_product", 64'(mif.product), 64'd0);

    // Release and start in the same cycle: first edge after reset accepts.
    rst_n = 1'b1;
    do_op(N'(3), N'(5), 1'b0);
    do_op(ones, ones, 1'b0);
    do_op(N'(0), N'(18'h2AAAA), 1'b0);
    do_op(N'(18'h2AAAA), N'(0), 1'b0);

    // Start held high through RUN must not queue a second operation.
    d0 = done_cnt;
    do_op(N'(7), N'(9), 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("no_restart_busy", 64'(mif.busy), 64'd0);
    end
    chk("no_restart_done", 64'(done_cnt - d0), 64'd1);
    do_op(N'(2), N'(2), 1'b0);

    // Reset ten cycles into a run aborts it.
    mif.a     = N'(100);
    mif.b     = N'(200);
    mif.start = 1'b1;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_run_busy", 64'(mif.busy), 64'd1);
    d0    = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(mif.busy), 64'd0);
    chk("abort_done", 64'(mif.done), 64'd0);
    chk("abort_product", 64'(mif.product), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 4) begin
      @(negedge clk);
      chk("post_abort_busy", 64'(mif.busy), 64'd0);
    end
    chk("post_abort_done", 64'(done_cnt - d0), 64'd0);
    do_op(N'(6), N'(7), 1'b0);

    // Randomized back-to-back operations with extra weight on edge values.
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0:       ra = '0;
        1:       ra = ones;
        default: ra = N'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = ones;
        default: rb = N'($urandom);
      endcase
      do_op(ra, rb, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have parameter N, default 18, giving the operand width in bits (N >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, N bits: unsigned multiplicand, sampled with an accepted start.
REQ-006 The block SHALL have port b, input, N bits: unsigned multiplier, sampled with an accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: high for exactly one cycle when product becomes valid.
REQ-009 The block SHALL have port product, output, 2N bits: last completed unsigned product a*b.

Function
REQ-010 The FSM SHALL have three states, IDLE, RUN and DONE, with transitions IDLE->RUN on start, RUN->DONE after N iterations, and DONE->IDLE unconditionally.
REQ-011 Start acceptance SHALL occur when start=1 at a rising edge while in IDLE, loading internal P[2N-1:0] <= {N'b0, b}, multiplicand register M <= a, iteration count <= 0, and state <= RUN.
REQ-012 Start SHALL be ignored in RUN and DONE, with no queuing and no effect on the operation in progress.
REQ-013 Each RUN edge with P[0]=1 SHALL compute {c, s} = P[2N-1:N] + M (N-bit add with carry-out) and set P <= {c, s, P[N-1:1]}.
REQ-014 Each RUN edge with P[0]=0 SHALL set P <= {1'b0, P[2N-1:1]}.
REQ-015 The count SHALL increment each RUN edge, and the iteration with count = N-1 SHALL move the state to DONE and capture that iteration's next-P value into the product register.
REQ-016 Latency SHALL be N cycles: with start accepted at edge t0, busy=1 after edges t0..t0+N-1, and done=1 and product valid after edge t0+N.
REQ-017 product SHALL hold its value from done until the next completion; it SHALL NOT change during RUN.
REQ-018 done and busy SHALL be registered or decoded from state only, with no combinational path from start.
REQ-019 Arithmetic SHALL be unsigned throughout, with no overflow possible since a 2N-bit result is exact.
REQ-020 The earliest back-to-back operation SHALL be a start accepted in the IDLE cycle following DONE, giving N+2 cycles per operation.

Reset
REQ-021 Assertion of rst_n=0 SHALL asynchronously force state=IDLE, busy=0, done=0, product=0, P=0, M=0 and count=0.
REQ-022 Reset asserted mid-RUN SHALL abort the operation, produce no done pulse, and require a new start after release.
REQ-023 The first rising edge after rst_n deasserts SHALL be able to accept start.

Structure
REQ-024 A shared package SHALL hold the FSM state enumeration (IDLE, RUN, DONE) and the default width constant 18.
REQ-025 The iteration adder SHALL be one instance of the team's N-bit ripple-carry adder sub-module, adderN, with Cin tied to 0 and Cout supplying c.
REQ-026 The count width SHALL be $clog2(N), and no other sub-modules are required.

Verification
REQ-027 A bench SHALL drive a=3, b=5, start for one cycle -> done after exactly 18 cycles, product=15, busy high for 18 cycles.
REQ-028 A bench SHALL drive a=0x3FFFF, b=0x3FFFF -> product=0xFFFF80001, with the carry-out path exercised.
REQ-029 A bench SHALL drive a=0, b=0x2AAAA, then a=0x2AAAA, b=0 -> product=0 both times, done pulses once per operation.
REQ-030 A bench SHALL start a=7, b=9, then hold start high with a=2, b=2 during RUN -> product=63, a single done, next operation only on a fresh start in IDLE.
REQ-031 A bench SHALL pulse rst_n low at cycle 10 of a run -> busy, done and product drop to 0 immediately, no done follows, and a new run of a=6, b=7 -> product=42.
REQ-032 A bench SHALL run a randomized back-to-back sequence of 1000 operands -> every product equals the a*b reference and each done is exactly one cycle.
